// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: builds a CRC7-protected 48-bit command frame, shifts it out on
// tx_tick, then captures and checks the card response sampled on rx_tick.
module sd_cmd_phy #(
    parameter int RESP_TIMEOUT = 64,
    parameter int GAP_TICKS    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_tick,
    input  logic         rx_tick,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         resp_valid,
    output logic [135:0] resp_data,
    output logic         resp_crc_err,
    output logic         resp_timeout,
    output logic         busy,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in
);
    localparam int WW = $clog2(RESP_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {IDLE, TX, WAIT_START, RX, GAP} state_t;

    state_t         state_q, state_d;
    logic [47:0]    frame_q, frame_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [1:0]     rtype_q, rtype_d;
    logic [134:0]   cap_q, cap_d;
    logic [6:0]     crc_q, crc_d;
    logic [135:0]   data_q, data_d;
    logic           rvalid_q, rvalid_d;
    logic           crcerr_q, crcerr_d;
    logic           tmo_q, tmo_d;
    logic           out_q, out_d;
    logic           oe_q, oe_d;
    logic [7:0]     nbits, hi, pos;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            gap_q    <= '0;
            rtype_q  <= '0;
            cap_q    <= '0;
            crc_q    <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
            crcerr_q <= 1'b0;
            tmo_q    <= 1'b0;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            rtype_q  <= rtype_d;
            cap_q    <= cap_d;
            crc_q    <= crc_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
            crcerr_q <= crcerr_d;
            tmo_q    <= tmo_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        gap_d    = gap_q;
        rtype_d  = rtype_q;
        cap_d    = cap_q;
        crc_d    = crc_q;
        data_d   = data_q;
        rvalid_d = 1'b0;
        crcerr_d = crcerr_q;
        tmo_d    = tmo_q;
        out_d    = out_q;
        oe_d     = oe_q;
        nbits    = (rtype_q == 2'b10) ? 8'd136 : 8'd48;
        hi       = (rtype_q == 2'b10) ? 8'd127 : 8'd47;
        pos      = nbits - 8'd1 - cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    frame_d = {2'b01, cmd_index, cmd_arg,
                               crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
                    rtype_d = resp_type;
                    cnt_d   = '0;
                    state_d = TX;
                end
            end
            TX: begin
                if (tx_tick) begin
                    if (cnt_q == 8'd48) begin
                        out_d   = 1'b1;
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        wait_d  = '0;
                        gap_d   = '0;
                        cap_d   = '0;
                        crc_d   = '0;
                        state_d = (rtype_q == 2'b00) ? GAP : WAIT_START;
                    end else begin
                        out_d   = frame_q[47];
                        oe_d    = 1'b1;
                        frame_d = {frame_q[46:0], 1'b1};
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            WAIT_START: begin
                // The start bit is zero, so it leaves the zero-initialised CRC untouched.
                if (rx_tick) begin
                    if (!cmd_in) begin
                        cnt_d   = 8'd1;
                        state_d = RX;
                    end else if (wait_q == WW'(RESP_TIMEOUT - 1)) begin
                        rvalid_d = 1'b1;
                        tmo_d    = 1'b1;
                        crcerr_d = 1'b0;
                        data_d   = '0;
                        state_d  = GAP;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
            end
            RX: begin
                if (rx_tick) begin
                    cap_d = {cap_q[133:0], cmd_in};
                    cnt_d = cnt_q + 8'd1;
                    if (pos >= 8'd8 && pos <= hi) crc_d = crc7_step(crc_q, cmd_in);
                    // Last bit: CRC over the covered range is final, bits 7:1 sit in cap_q[6:0].
                    if (cnt_q == nbits - 8'd1) begin
                        rvalid_d = 1'b1;
                        tmo_d    = 1'b0;
                        data_d   = {cap_q, cmd_in};
                        crcerr_d = !cmd_in || (rtype_q != 2'b11 && crc_q != cap_q[6:0]);
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                if (tx_tick) begin
                    if (gap_q == GW'(GAP_TICKS - 1)) state_d = IDLE;
                    else gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign resp_valid   = rvalid_q;
    assign resp_data    = data_q;
    assign resp_crc_err = crcerr_q;
    assign resp_timeout = tmo_q;
    assign cmd_out      = out_q;
    assign cmd_oe       = oe_q;
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboard bench for sd_cmd_phy: a card model replays responses, monitors check
// transmitted frames, response results and gap length against a polynomial-division model.
module tb_sd_cmd_phy;
    localparam int RESP_TIMEOUT = 64;
    localparam int GAP_TICKS    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_tick = 1'b0;
    logic         rx_tick = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         resp_valid;
    logic [135:0] resp_data;
    logic         resp_crc_err;
    logic         resp_timeout;
    logic         busy;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_in = 1'b1;

    sd_cmd_phy #(.RESP_TIMEOUT(RESP_TIMEOUT), .GAP_TICKS(GAP_TICKS)) dut (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .rx_tick(rx_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
        .busy(busy), .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_in(cmd_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [135:0] data;
        logic         err;
        logic         tmo;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] exp_frame_q[$];
    bit          card_q[$];
    bit          txbits[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          both_mode = 0;

    function automatic void chk(input string name, input logic [135:0] got, input logic [135:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    function automatic void chk1(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endfunction

    function automatic void chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endfunction

    // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1 (long division).
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int len);
        logic [126:0] r;
        logic [7:0]   g;
        g = 8'h89;
        r = '0;
        for (int i = 0; i < len; i++) r[i+7] = msg[i];
        for (int i = len + 6; i >= 7; i--)
            if (r[i]) for (int j = 0; j < 8; j++) r[i-7+j] = r[i-7+j] ^ g[j];
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_ref({80'b0, m}, 40), 1'b1};
    endfunction

    function automatic logic resp_err_ref(input logic [1:0] rt, input logic [135:0] rsp);
        logic bad;
        bad = !rsp[0];
        if (rt == 2'b01) bad = bad | (crc7_ref({80'b0, rsp[47:8]}, 40) != rsp[7:1]);
        if (rt == 2'b10) bad = bad | (crc7_ref(rsp[127:8], 120) != rsp[7:1]);
        return bad;
    endfunction

    function automatic logic [135:0] mk_rsp(input logic [1:0] rt, input logic [5:0] idx,
                                            input logic [31:0] a, input logic [119:0] body);
        logic [39:0] m;
        if (rt == 2'b10) return {8'h3F, body, crc7_ref(body, 120), 1'b1};
        m = {2'b00, idx, a};
        return {88'b0, m, (rt == 2'b11) ? 7'h7F : crc7_ref({80'b0, m}, 40), 1'b1};
    endfunction

    // Tick generator, card model, TX frame monitor and gap monitor, all at negedge.
    int  phase = 0;
    int  gap_cnt = 0;
    bit  card_arm = 0, gap_arm = 0, prev_oe = 0, prev_rdy = 1;
    always @(negedge clk) begin : drv
        logic [47:0] got, want;
        if (rst) begin
            txbits.delete();
            prev_oe  = 0;
            prev_rdy = 1;
            card_arm = 0;
            gap_arm  = 0;
        end else begin
            if (card_arm && rx_tick && card_q.size() > 0) void'(card_q.pop_front());
            if (tx_tick && cmd_oe) txbits.push_back(cmd_out);
            if (tx_tick) gap_cnt++;
            if (prev_oe && !cmd_oe) begin
                card_arm = 1;
                gap_arm  = 1;
                gap_cnt  = 0;
                chk_int("tx_len", txbits.size(), 48);
                got = '0;
                foreach (txbits[i]) got = {got[46:0], txbits[i]};
                if (exp_frame_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame got=%0h want=none", got);
                end else begin
                    want = exp_frame_q.pop_front();
                    chk("tx_frame", {88'b0, got}, {88'b0, want});
                end
                txbits.delete();
            end
            if (resp_valid) gap_cnt = 0;
            if (cmd_ready && !prev_rdy) begin
                if (gap_arm) chk_int("gap_ticks", gap_cnt, GAP_TICKS);
                gap_arm  = 0;
                card_arm = 0;
            end
            prev_oe  = cmd_oe;
            prev_rdy = cmd_ready;
        end
        cmd_in  = (card_arm && card_q.size() > 0) ? card_q[0] : 1'b1;
        phase   = (phase + 1) % 4;
        tx_tick = (phase == 0);
        rx_tick = both_mode ? (phase == 0) : (phase == 2);
    end

    // Response monitor: pops the scoreboard whenever resp_valid is presented.
    bit prev_rv = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_resp_valid got=1 want=0");
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk1("resp_crc_err", resp_crc_err, e.err);
                chk1("resp_timeout", resp_timeout, e.tmo);
            end
            if (prev_rv) begin
                n_cmp++; n_bad++;
                $display("FAIL resp_valid_width got=2+ want=1");
            end
        end
        prev_rv = resp_valid;
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(posedge clk); #2;
        while (!cmd_ready && k < 6000) begin
            @(posedge clk); #2;
            k++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout got=0 want=1");
        end
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [135:0] rsp, input bit reply, input int dly);
        exp_t e;
        int   n;
        wait_ready();
        n = (rt == 2'b10) ? 136 : 48;
        exp_frame_q.push_back(frame_ref(idx, arg));
        card_q.delete();
        if (rt != 2'b00) begin
            if (reply) begin
                repeat (dly) card_q.push_back(1'b1);
                for (int i = n - 1; i >= 0; i--) card_q.push_back(rsp[i]);
            end
            if (reply && dly < RESP_TIMEOUT) begin
                e.data = rsp; e.err = resp_err_ref(rt, rsp); e.tmo = 1'b0;
            end else begin
                e.data = '0; e.err = 1'b0; e.tmo = 1'b1;
            end
            exp_q.push_back(e);
        end
        cmd_index = idx; cmd_arg = arg; resp_type = rt; cmd_valid = 1'b1;
        @(posedge clk); #2;
        chk1("ready_drop", cmd_ready, 1'b0);
        chk1("busy_rise", busy, 1'b1);
        // Garbage requests while busy must be ignored.
        repeat (4) begin
            cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
            @(posedge clk); #2;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete(); exp_frame_q.delete(); card_q.delete();
        cmd_valid = 1'b0;
        #1;
        chk1("rst_cmd_oe", cmd_oe, 1'b0);
        chk1("rst_cmd_out", cmd_out, 1'b1);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [135:0] r;
        logic [127:0] b128;
        repeat (3) @(posedge clk);
        #2;
        chk1("reset_cmd_out", cmd_out, 1'b1);
        chk1("reset_cmd_oe", cmd_oe, 1'b0);
        chk1("reset_cmd_ready", cmd_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_resp_valid", resp_valid, 1'b0);
        chk1("reset_crc_err", resp_crc_err, 1'b0);
        chk1("reset_timeout", resp_timeout, 1'b0);
        chk("reset_resp_data", resp_data, 136'b0);
        rst = 1'b0;

        issue(6'd0, 32'h0, 2'b00, '0, 1'b0, 0);
        issue(6'd8, 32'h1AA, 2'b01, 136'h08000001AA13, 1'b1, 2);
        issue(6'd8, 32'h1AA, 2'b01, 136'h08000001AA1B, 1'b1, 2);
        issue(6'd17, 32'h0, 2'b01, '0, 1'b0, 0);
        b128 = {$urandom, $urandom, $urandom, $urandom};
        r = mk_rsp(2'b10, 6'd0, 32'h0, b128[119:0]);
        issue(6'd2, 32'h0, 2'b10, r, 1'b1, 1);
        r = mk_rsp(2'b11, 6'h3F, 32'h80FF8000, '0);
        issue(6'd41, 32'h40300000, 2'b11, r, 1'b1, 3);

        // Start-bit search window edges.
        r = mk_rsp(2'b01, 6'd13, 32'h00000900, '0);
        issue(6'd13, 32'h12340000, 2'b01, r, 1'b1, RESP_TIMEOUT - 1);
        issue(6'd13, 32'h12340000, 2'b01, r, 1'b1, RESP_TIMEOUT);

        // Reset in the middle of TX.
        issue(6'd55, 32'hDEAD0000, 2'b01, mk_rsp(2'b01, 6'd55, 32'h120, '0), 1'b1, 0);
        repeat (100) @(posedge clk);
        #2;
        chk1("mid_tx_oe", cmd_oe, 1'b1);
        do_reset();
        issue(6'd9, 32'hABCD0000, 2'b01, mk_rsp(2'b01, 6'd9, 32'h0BAD_F00D, '0), 1'b1, 1);

        // Reset in the middle of RX.
        issue(6'd8, 32'h1AA, 2'b01, 136'h08000001AA13, 1'b1, 0);
        repeat (250) @(posedge clk);
        #2;
        chk1("mid_rx_busy", busy, 1'b1);
        chk1("mid_rx_oe", cmd_oe, 1'b0);
        do_reset();
        issue(6'd8, 32'h1AA, 2'b01, 136'h08000001AA13, 1'b1, 2);

        for (int t = 0; t < 16; t++) begin : rnd
            logic [1:0]  rt;
            logic [5:0]  idx;
            logic [31:0] arg;
            int          dly, kind, n;
            bit          reply;
            both_mode = 1'($urandom);
            rt    = 2'($urandom);
            idx   = 6'($urandom);
            arg   = $urandom;
            reply = ($urandom_range(0, 5) != 0);
            dly   = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 66) : $urandom_range(0, 5);
            b128  = {$urandom, $urandom, $urandom, $urandom};
            r     = mk_rsp(rt, (rt == 2'b11) ? 6'h3F : idx, $urandom, b128[119:0]);
            n     = (rt == 2'b10) ? 136 : 48;
            kind  = $urandom_range(0, 3);
            if (kind == 0) begin
                int p;
                p = $urandom_range(1, n - 2);
                r[p] = ~r[p];
            end else if (kind == 1) begin
                r[0] = 1'b0;
            end
            issue(idx, arg, rt, r, reply, dly);
        end

        wait_ready();
        repeat (20) @(posedge clk);
        chk_int("leftover_resp", exp_q.size(), 0);
        chk_int("leftover_frames", exp_frame_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
